dsp_mult_bank: RTL and testbench
================================

# dsp_mult_bank

Five-lane pipelined 18x18 unsigned multiply-accumulate bank that answers the DSP request interface driven by `matrix_convolution`. It stands in for the FPGA DSP slices behind the convolution engine, for both synthesis and simulation. It samples `dsp_a0`/`dsp_b0` on `dsp_ce` and returns `dsp_out` a fixed number of cycles later, flagged by `dsp_valid`. Optional per-request accumulation and sticky per-lane saturation let the engine sum a 3x3 window in the bank.

## Interface
- `LANES`, 5: number of parallel multiplier lanes.
- `LATENCY`, 3: cycles from a `dsp_ce` sample to `dsp_valid`; legal range 2..6.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `dsp_ce` in 1: request strobe; operands are sampled when high.
- `dsp_acc` in 1: qualified by `dsp_ce`. 1 adds the product to the lane's current output; 0 replaces it.
- `dsp_a0[LANES]` in 18: unsigned multiplicand per lane.
- `dsp_b0[LANES]` in 18: unsigned multiplier per lane.
- `dsp_out[LANES]` out 37: per-lane product or accumulated sum.
- `dsp_valid` out 1: one-cycle pulse; `dsp_out` holds a newly completed result.
- `dsp_ovf[LANES]` out 1: sticky saturation flag per lane.

## Operation
- All lanes share `dsp_ce`, `dsp_acc` and the valid pipeline. There are no per-lane enables.
- Stage 1 registers the operands, the `acc` flag and `valid = dsp_ce`.
- The 36-bit product `a*b` is formed in stage 2 and delayed through stages 2..`LATENCY`-1.
- Final stage, only when its valid bit is 1:
  - `acc`=0: `dsp_out <= {1'b0, p}`.
  - `acc`=1: `dsp_out <= dsp_out + p`, computed 38 bits wide.
  - If the sum exceeds 2^37-1, `dsp_out <= 37'h1F_FFFF_FFFF` and `dsp_ovf[lane] <= 1`.
- A non-accumulate result (`acc`=0) clears that lane's `dsp_ovf`.
- When the final-stage valid bit is 0, `dsp_out` and `dsp_ovf` hold their values.
- Back-to-back requests (`dsp_ce` high on consecutive cycles) are fully supported. Throughput is one request per cycle and there is no stall or backpressure.
- Accumulation uses the value registered by the previous valid result. A chain of consecutive `dsp_acc`=1 requests therefore sums correctly at full rate.
- `dsp_acc`=1 on the first request after reset adds to 0.

## Timing
- Request sampled at edge N: the result is visible, with `dsp_valid`=1, after edge N+`LATENCY`-1, i.e. during cycle N+`LATENCY`-1.
- `LATENCY`=3 timeline: `dsp_ce` high in cycle 0 → `dsp_valid` high in cycle 2.
- `dsp_valid` pulses once per sampled request, in request order, with no gaps added.
- Reset values: `dsp_out`=0, `dsp_valid`=0, `dsp_ovf`=0, all pipeline valid bits=0.
- Reset asserted mid-operation:
  - All in-flight requests are discarded. No `dsp_valid` appears for them after release.
  - Accumulators and overflow flags are cleared.
- First sample after reset release: `dsp_ce` is honoured on the first rising edge with `rst` low.
- The operand buses are don't-care while `dsp_ce`=0. They must not affect `dsp_out`.

## Structure
- Shared package `npu_dsp_pkg` holds:
  - `DSP_OPW`=18, `DSP_PRODW`=36, `DSP_OUTW`=37, `DSP_LANES`=5.
  - `DSP_SAT_MAX` (all ones, `DSP_OUTW` bits).
  - `dsp_req_t` struct {`ce`, `acc`}.
- One sub-module, `dsp_mac_lane`: operand registers, product delay line, accumulate/saturate register and overflow flag for one lane. It is instantiated `LANES` times.
- The top level owns the shared valid/acc shift register and `dsp_valid`.

## Test plan
- Reset then single request, `LATENCY`=3:
  - Stimulus: all lanes a=1, b=1, acc=0, one `dsp_ce` pulse.
  - Required: one `dsp_valid` pulse 2 cycles later, all `dsp_out`=1, `dsp_ovf`=0.
- 3x3 window accumulation:
  - Stimulus: 9 consecutive requests with a=b=1; acc=0 on the first, 1 on the rest.
  - Required: 9 consecutive `dsp_valid` pulses, final `dsp_out`=9 on all lanes (matches the convolution's expected 16'h09).
- Max operands and saturation:
  - Stimulus: lane 0 a=b=18'h3FFFF, acc=0.
  - Required: `dsp_out` 36'hF_FFF8_0001.
  - Then two acc=1 repeats → `dsp_out` saturates at 37'h1F_FFFF_FFFF and `dsp_ovf[0]`=1 stays sticky.
  - A later acc=0 request with a=2, b=3 → `dsp_out`=6, `dsp_ovf[0]`=0.
- Gapped traffic:
  - Stimulus: `dsp_ce` pattern 1,0,1,1,0 with distinct per-lane operands.
  - Required: `dsp_valid` pattern 1,0,1,1,0 delayed by `LATENCY`-1, correct products, outputs held in gap cycles while the operand buses carry random data.
- Reset mid-flight:
  - Stimulus: 3 requests issued, `rst` pulsed one cycle later.
  - Required: outputs go to 0 asynchronously and no `dsp_valid` appears for the dropped requests.
- Parameter sweep: repeat the first test with `LATENCY`=2 and 6; `dsp_valid` arrives exactly `LATENCY`-1 cycles after the sample.

Source files
------------

// File: rtl/npu_dsp_pkg.sv
// Shared widths, constants and request type for the DSP multiply bank
// that sits behind the convolution engine.
package npu_dsp_pkg;

  localparam int DSP_OPW   = 18;
  localparam int DSP_PRODW = 36;
  localparam int DSP_OUTW  = 37;
  localparam int DSP_LANES = 5;

  localparam logic [DSP_OUTW-1:0] DSP_SAT_MAX = {DSP_OUTW{1'b1}};

  typedef struct packed {
    logic ce;
    logic acc;
  } dsp_req_t;

endpackage

// File: rtl/dsp_mult_bank_if.sv
// Request/response bundle between the convolution engine (master) and
// the DSP multiply bank (slave).
interface dsp_mult_bank_if #(
  parameter int LANES = npu_dsp_pkg::DSP_LANES
);
  import npu_dsp_pkg::*;

  logic                dsp_ce;
  logic                dsp_acc;
  logic [DSP_OPW-1:0]  dsp_a0 [LANES];
  logic [DSP_OPW-1:0]  dsp_b0 [LANES];
  logic [DSP_OUTW-1:0] dsp_out [LANES];
  logic                dsp_valid;
  logic [LANES-1:0]    dsp_ovf;

  modport master (
    output dsp_ce, dsp_acc, dsp_a0, dsp_b0,
    input  dsp_out, dsp_valid, dsp_ovf
  );

  modport slave (
    input  dsp_ce, dsp_acc, dsp_a0, dsp_b0,
    output dsp_out, dsp_valid, dsp_ovf
  );

endinterface

// File: rtl/dsp_mac_lane.sv
// One multiply-accumulate lane: operand capture, product delay line and
// the saturating accumulator with its sticky overflow flag.
module dsp_mac_lane
  import npu_dsp_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [DSP_OPW-1:0]  a,
  input  logic [DSP_OPW-1:0]  b,
  input  logic                fin_valid,
  input  logic                fin_acc,
  output logic [DSP_OUTW-1:0] acc_out,
  output logic                ovf
);

  logic [DSP_OPW-1:0]   a_r;
  logic [DSP_OPW-1:0]   b_r;
  logic [DSP_PRODW-1:0] prod_s;
  logic [DSP_PRODW-1:0] fin_prod_s;
  logic [DSP_OUTW:0]    sum_s;
  logic [DSP_OUTW-1:0]  out_r;
  logic [DSP_OUTW-1:0]  out_nxt_s;
  logic                 ovf_r;
  logic                 ovf_nxt_s;

  // Stage 1: operands only load on a request, so idle bus noise never reaches the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= {DSP_OPW{1'b0}};
      b_r <= {DSP_OPW{1'b0}};
    end else if (ce) begin
      a_r <= a;
      b_r <= b;
    end
  end

  assign prod_s = {{(DSP_PRODW-DSP_OPW){1'b0}}, a_r} * {{(DSP_PRODW-DSP_OPW){1'b0}}, b_r};

  if (LATENCY > 2) begin : g_pipe
    logic [DSP_PRODW-1:0] prod_pipe_r [LATENCY-2];

    // Product delay line covering stages 2..LATENCY-1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY-2; i++) begin
          prod_pipe_r[i] <= {DSP_PRODW{1'b0}};
        end
      end else begin
        prod_pipe_r[0] <= prod_s;
        for (int i = 1; i < LATENCY-2; i++) begin
          prod_pipe_r[i] <= prod_pipe_r[i-1];
        end
      end
    end

    assign fin_prod_s = prod_pipe_r[LATENCY-3];
  end else begin : g_nopipe
    assign fin_prod_s = prod_s;
  end

  // One guard bit catches any carry past the 37-bit accumulator.
  assign sum_s = {1'b0, out_r} + {2'b00, fin_prod_s};

  // Final-stage next state: replace, accumulate, saturate, or hold.
  always_comb begin
    out_nxt_s = out_r;
    ovf_nxt_s = ovf_r;
    if (fin_valid) begin
      if (fin_acc) begin
        if (sum_s[DSP_OUTW]) begin
          out_nxt_s = DSP_SAT_MAX;
          ovf_nxt_s = 1'b1;
        end else begin
          out_nxt_s = sum_s[DSP_OUTW-1:0];
          ovf_nxt_s = ovf_r;
        end
      end else begin
        out_nxt_s = {1'b0, fin_prod_s};
        ovf_nxt_s = 1'b0;
      end
    end else begin
      out_nxt_s = out_r;
      ovf_nxt_s = ovf_r;
    end
  end

  // Final stage: result and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= {DSP_OUTW{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      out_r <= out_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign acc_out = out_r;
  assign ovf     = ovf_r;

endmodule

// File: rtl/dsp_mult_bank.sv
// Five-lane pipelined 18x18 multiply-accumulate bank; all lanes share one
// request strobe, one accumulate flag and one valid pipeline.
module dsp_mult_bank
  import npu_dsp_pkg::*;
#(
  parameter int LANES   = DSP_LANES,
  parameter int LATENCY = 3
) (
  input  logic           clk,
  input  logic           rst,
  dsp_mult_bank_if.slave bus
);

  dsp_req_t req_pipe_r [LATENCY-1];
  dsp_req_t fin_req_s;
  logic     valid_r;

  // Shared ce/acc shift register; acc is qualified by ce on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY-1; i++) begin
        req_pipe_r[i] <= '{ce: 1'b0, acc: 1'b0};
      end
      valid_r <= 1'b0;
    end else begin
      req_pipe_r[0] <= '{ce: bus.dsp_ce, acc: bus.dsp_ce & bus.dsp_acc};
      for (int i = 1; i < LATENCY-1; i++) begin
        req_pipe_r[i] <= req_pipe_r[i-1];
      end
      valid_r <= req_pipe_r[LATENCY-2].ce;
    end
  end

  assign fin_req_s     = req_pipe_r[LATENCY-2];
  assign bus.dsp_valid = valid_r;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dsp_mac_lane #(
      .LATENCY (LATENCY)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .ce        (bus.dsp_ce),
      .a         (bus.dsp_a0[g]),
      .b         (bus.dsp_b0[g]),
      .fin_valid (fin_req_s.ce),
      .fin_acc   (fin_req_s.acc),
      .acc_out   (bus.dsp_out[g]),
      .ovf       (bus.dsp_ovf[g])
    );
  end

endmodule

// File: tb/tb_dsp_mult_bank.sv
// Randomized bench for dsp_mult_bank with an in-order result scoreboard
// for the LATENCY=3 instance and timing checks on LATENCY=2 and 6 copies.
module tb_dsp_mult_bank;
  import npu_dsp_pkg::*;

  localparam int LAT = 3;
  localparam int NL  = 5;
  localparam longint unsigned SATV = 64'h1F_FFFF_FFFF;

  typedef struct packed {
    int               due;
    logic [4:0][36:0] out;
    logic [4:0]       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp_mult_bank_if #(.LANES(NL)) bif ();
  dsp_mult_bank_if #(.LANES(NL)) if2 ();
  dsp_mult_bank_if #(.LANES(NL)) if6 ();

  assign if2.dsp_ce  = bif.dsp_ce;
  assign if2.dsp_acc = bif.dsp_acc;
  assign if2.dsp_a0  = bif.dsp_a0;
  assign if2.dsp_b0  = bif.dsp_b0;
  assign if6.dsp_ce  = bif.dsp_ce;
  assign if6.dsp_acc = bif.dsp_acc;
  assign if6.dsp_a0  = bif.dsp_a0;
  assign if6.dsp_b0  = bif.dsp_b0;

  dsp_mult_bank #(.LANES(NL), .LATENCY(LAT)) dut  (.clk(clk), .rst(rst), .bus(bif));
  dsp_mult_bank #(.LANES(NL), .LATENCY(2))   dut2 (.clk(clk), .rst(rst), .bus(if2));
  dsp_mult_bank #(.LANES(NL), .LATENCY(6))   dut6 (.clk(clk), .rst(rst), .bus(if6));

  exp_t            q[$];
  longint unsigned m_out [NL];
  logic            m_ovf [NL];
  logic [36:0]     e_out [NL];
  logic            e_ovf [NL];
  int              cyc   = 0;
  int              n_vec = 0;
  int              n_err = 0;
  bit              chk_en = 1'b0;

  task automatic model_clear();
    q.delete();
    for (int l = 0; l < NL; l++) begin
      m_out[l] = 64'd0;
      m_ovf[l] = 1'b0;
    end
  endtask

  // Reference: accumulate in 64-bit arithmetic and clamp at 2^37-1.
  task automatic model_issue(input logic acc);
    exp_t e;
    longint unsigned p;
    e.due = cyc + LAT - 1;
    for (int l = 0; l < NL; l++) begin
      p = longint'(bif.dsp_a0[l]) * longint'(bif.dsp_b0[l]);
      if (acc) begin
        if (m_out[l] + p > SATV) begin
          m_out[l] = SATV;
          m_ovf[l] = 1'b1;
        end else begin
          m_out[l] = m_out[l] + p;
        end
      end else begin
        m_out[l] = p;
        m_ovf[l] = 1'b0;
      end
      e.out[l] = m_out[l][36:0];
      e.ovf[l] = m_ovf[l];
    end
    q.push_back(e);
  endtask

  task automatic rand_ops();
    for (int l = 0; l < NL; l++) begin
      bif.dsp_a0[l] = 18'($urandom);
      bif.dsp_b0[l] = 18'($urandom);
    end
  endtask

  task automatic set_ops(input logic [17:0] a, input logic [17:0] b);
    for (int l = 0; l < NL; l++) begin
      bif.dsp_a0[l] = a;
      bif.dsp_b0[l] = b;
    end
  endtask

  // One clock: caller has set operands for a request; idle cycles get noise.
  task automatic step(input logic ce, input logic acc);
    bif.dsp_ce  = ce;
    bif.dsp_acc = ce ? acc : 1'($urandom);
    if (!ce) rand_ops();
    @(posedge clk);
    cyc++;
    if (ce && !rst) model_issue(acc);
    #1;
  endtask

  // Scoreboard for the LATENCY=3 instance, sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    logic exp_v;
    if (chk_en) begin
      exp_v = 1'b0;
      if (rst) begin
        for (int l = 0; l < NL; l++) begin
          e_out[l] = 37'd0;
          e_ovf[l] = 1'b0;
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        exp_v = (e.due == cyc);
        for (int l = 0; l < NL; l++) begin
          e_out[l] = e.out[l];
          e_ovf[l] = e.ovf[l];
        end
      end
      n_vec++;
      if (bif.dsp_valid !== exp_v)
        begin n_err++; $display("FAIL sb_valid cyc=%0d: got %b want %b", cyc, bif.dsp_valid, exp_v); end
      for (int l = 0; l < NL; l++) begin
        n_vec++;
        if (bif.dsp_out[l] !== e_out[l] || bif.dsp_ovf[l] !== e_ovf[l]) begin
          n_err++;
          $display("FAIL sb_lane%0d cyc=%0d: got %h/%b want %h/%b", l, cyc, bif.dsp_out[l], bif.dsp_ovf[l], e_out[l], e_ovf[l]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bif.dsp_ce = 1'b0;
    bif.dsp_acc = 1'b0;
    set_ops(18'd0, 18'd0);
    model_clear();
    step(1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b0);
    for (int l = 0; l < NL; l++) begin
      n_vec++;
      if (bif.dsp_out[l] !== 37'd0 || bif.dsp_ovf[l] !== 1'b0)
        begin n_err++; $display("FAIL reset_lane%0d: got %h/%b want 0/0", l, bif.dsp_out[l], bif.dsp_ovf[l]); end
    end
    n_vec++;
    if (bif.dsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bif.dsp_valid); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_ops(18'd1, 18'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (bif.dsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b want 0", bif.dsp_valid); end
    step(1'b0, 1'b0);
    n_vec++;
    if (bif.dsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bif.dsp_valid); end
    for (int l = 0; l < NL; l++) begin
      n_vec++;
      if (bif.dsp_out[l] !== 37'd1 || bif.dsp_ovf[l] !== 1'b0)
        begin n_err++; $display("FAIL single_lane%0d: got %h/%b want 1/0", l, bif.dsp_out[l], bif.dsp_ovf[l]); end
    end
    step(1'b0, 1'b0);
    n_vec++;
    if (bif.dsp_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b want 0", bif.dsp_valid); end
  endtask

  task automatic test_window();
    int nv;
    nv = 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 9) set_ops(18'd1, 18'd1);
      step(k < 9, k != 0);
      if (bif.dsp_valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv !== 9) begin n_err++; $display("FAIL window_pulses: got %0d want 9", nv); end
    for (int l = 0; l < NL; l++) begin
      n_vec++;
      if (bif.dsp_out[l] !== 37'd9) begin n_err++; $display("FAIL window_lane%0d: got %0d want 9", l, bif.dsp_out[l]); end
    end
  endtask

  task automatic test_saturate();
    rand_ops();
    bif.dsp_a0[0] = 18'h3FFFF;
    bif.dsp_b0[0] = 18'h3FFFF;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (bif.dsp_out[0] !== 37'h0F_FFF8_0001)
      begin n_err++; $display("FAIL sat_maxprod: got %h want 0fffff80001", bif.dsp_out[0]); end
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      bif.dsp_a0[0] = (k < 2) ? 18'h3FFFF : 18'd5;
      bif.dsp_b0[0] = (k < 2) ? 18'h3FFFF : 18'd7;
      step(1'b1, 1'b1);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (bif.dsp_out[0] !== 37'h1F_FFFF_FFFF || bif.dsp_ovf[0] !== 1'b1)
      begin n_err++; $display("FAIL sat_sticky: got %h/%b want 1fffffffff/1", bif.dsp_out[0], bif.dsp_ovf[0]); end
    rand_ops();
    bif.dsp_a0[0] = 18'd2;
    bif.dsp_b0[0] = 18'd3;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_vec++;
    if (bif.dsp_out[0] !== 37'd6 || bif.dsp_ovf[0] !== 1'b0)
      begin n_err++; $display("FAIL sat_clear: got %h/%b want 6/0", bif.dsp_out[0], bif.dsp_ovf[0]); end
  endtask

  task automatic test_gapped();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic ce;
    for (int k = 0; k < 7; k++) begin
      ce = (k < 5) ? pat[k] : 1'b0;
      if (ce) rand_ops();
      step(ce, 1'b0);
      if (k >= LAT-1) begin
        n_vec++;
        if (bif.dsp_valid !== pat[k-(LAT-1)])
          begin n_err++; $display("FAIL gap_valid k=%0d: got %b want %b", k, bif.dsp_valid, pat[k-(LAT-1)]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ce;
    for (int k = 0; k < 80; k++) begin
      ce = ($urandom_range(3) != 0);
      for (int l = 0; l < NL; l++) begin
        bif.dsp_a0[l] = ($urandom_range(3) == 0) ? 18'($urandom) : 18'($urandom_range(255));
        bif.dsp_b0[l] = ($urandom_range(3) == 0) ? 18'($urandom) : 18'($urandom_range(255));
      end
      step(ce, 1'($urandom));
    end
    for (int k = 0; k < LAT; k++) step(1'b0, 1'b0);
  endtask

  task automatic test_reset_midflight();
    int nv;
    nv = 0;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      step(1'b1, 1'($urandom));
    end
    step(1'b0, 1'b0);
    rst = 1'b1;
    model_clear();
    #1;
    n_vec++;
    if (bif.dsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bif.dsp_valid); end
    for (int l = 0; l < NL; l++) begin
      n_vec++;
      if (bif.dsp_out[l] !== 37'd0 || bif.dsp_ovf[l] !== 1'b0)
        begin n_err++; $display("FAIL mid_lane%0d: got %h/%b want 0/0", l, bif.dsp_out[l], bif.dsp_ovf[l]); end
    end
    step(1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0);
      if (bif.dsp_valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv !== 0) begin n_err++; $display("FAIL mid_ghost: got %0d pulses want 0", nv); end
  endtask

  task automatic test_latency_sweep();
    logic [17:0] a_s [NL];
    logic [17:0] b_s [NL];
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0);
    rand_ops();
    for (int l = 0; l < NL; l++) begin
      a_s[l] = bif.dsp_a0[l];
      b_s[l] = bif.dsp_b0[l];
    end
    step(1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0);
      n_vec += 2;
      if (if2.dsp_valid !== (k == 1))
        begin n_err++; $display("FAIL lat2_valid k=%0d: got %b want %b", k, if2.dsp_valid, (k == 1)); end
      if (if6.dsp_valid !== (k == 5))
        begin n_err++; $display("FAIL lat6_valid k=%0d: got %b want %b", k, if6.dsp_valid, (k == 5)); end
      for (int l = 0; l < NL; l++) begin
        if (k == 1) begin
          n_vec++;
          if (if2.dsp_out[l] !== 37'(longint'(a_s[l]) * longint'(b_s[l])))
            begin n_err++; $display("FAIL lat2_lane%0d: got %h", l, if2.dsp_out[l]); end
        end
        if (k == 5) begin
          n_vec++;
          if (if6.dsp_out[l] !== 37'(longint'(a_s[l]) * longint'(b_s[l])))
            begin n_err++; $display("FAIL lat6_lane%0d: got %h", l, if6.dsp_out[l]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_window();
    test_saturate();
    test_gapped();
    test_back_to_back();
    test_reset_midflight();
    test_back_to_back();
    test_latency_sweep();
    n_vec++;
    if (q.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending want 0", q.size()); end
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
